// File: rtl/display_link_rx.sv
// UART 8N1 receiver and 4-byte frame parser (sync, addr, data, checksum) that
// issues one register write per valid frame and flags dropped bytes/frames.
module display_link_rx #(
    parameter int unsigned CLKS_PER_BIT  = 434,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter int unsigned MAX_ADDR      = 5,
    parameter int unsigned TIMEOUT_BYTES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [2:0] addr,
    output logic [7:0] data_out,
    output logic       write,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF     = CLKS_PER_BIT / 2;
    localparam int unsigned TO_LIMIT = TIMEOUT_BYTES * 10 * CLKS_PER_BIT;
    localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);

    typedef enum logic [2:0] {U_IDLE, U_START, U_DATA, U_STOP, U_BREAK} uart_t;
    typedef enum logic [1:0] {P_HUNT, P_ADDR, P_DATA, P_CSUM} parse_t;

    uart_t            u_state, u_next;
    parse_t           p_state, p_next;
    logic             rx_meta, rx_sync;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_q;
    logic [TO_W-1:0]  to_cnt;
    logic [2:0]       addr_byte;
    logic [7:0]       data_byte;

    logic half_done_c, bit_done_c, tick_c, start_det_c;
    logic byte_valid_c, stop_err_c, to_run_c, timeout_c;
    logic err_c, write_c, latch_addr_c, latch_data_c;
    logic [7:0] csum_c;

    assign half_done_c  = (clk_cnt == CNT_W'(HALF - 1));
    assign bit_done_c   = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign tick_c       = ((u_state == U_START) && half_done_c) ||
                          (((u_state == U_DATA) || (u_state == U_STOP)) && bit_done_c);
    assign start_det_c  = (u_state == U_IDLE) && !rx_sync;
    assign byte_valid_c = (u_state == U_STOP) && bit_done_c && rx_sync;
    assign stop_err_c   = (u_state == U_STOP) && bit_done_c && !rx_sync;
    assign to_run_c     = (p_state != P_HUNT) && (u_state == U_IDLE) && rx_sync;
    assign timeout_c    = to_run_c && (to_cnt == TO_W'(TO_LIMIT - 1));
    assign csum_c       = SYNC_BYTE + {5'b0, addr_byte} + data_byte;

    // State registers, synchroniser and UART datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            u_state <= U_IDLE;
            p_state <= P_HUNT;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift_q <= '0;
            to_cnt  <= '0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            u_state <= u_next;
            p_state <= p_next;
            clk_cnt <= ((u_state == U_IDLE) || (u_state == U_BREAK) || tick_c)
                       ? '0 : clk_cnt + CNT_W'(1);
            if (u_state == U_IDLE) begin
                bit_cnt <= '0;
            end else if ((u_state == U_DATA) && bit_done_c) begin
                bit_cnt <= bit_cnt + 3'd1;
                shift_q <= {rx_sync, shift_q[7:1]};
            end
            if ((p_state == P_HUNT) || start_det_c) begin
                to_cnt <= '0;
            end else if (to_run_c) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    // UART next state; a low stop bit parks in BREAK until the line idles
    always_comb begin
        u_next = u_state;
        case (u_state)
            U_IDLE:  if (!rx_sync) u_next = U_START;
            U_START: if (half_done_c) u_next = rx_sync ? U_IDLE : U_DATA;
            U_DATA:  if (bit_done_c && (bit_cnt == 3'd7)) u_next = U_STOP;
            U_STOP:  if (bit_done_c) u_next = rx_sync ? U_IDLE : U_BREAK;
            U_BREAK: if (rx_sync) u_next = U_IDLE;
            default: u_next = U_IDLE;
        endcase
    end

    // Parser next state and write/error decisions
    always_comb begin
        p_next       = p_state;
        err_c        = 1'b0;
        write_c      = 1'b0;
        latch_addr_c = 1'b0;
        latch_data_c = 1'b0;
        if (stop_err_c || timeout_c) begin
            err_c  = 1'b1;
            p_next = P_HUNT;
        end else if (byte_valid_c) begin
            case (p_state)
                P_HUNT: if (shift_q == SYNC_BYTE) p_next = P_ADDR;
                P_ADDR: begin
                    if (shift_q <= 8'(MAX_ADDR)) begin
                        latch_addr_c = 1'b1;
                        p_next       = P_DATA;
                    end else begin
                        err_c  = 1'b1;
                        p_next = P_HUNT;
                    end
                end
                P_DATA: begin
                    latch_data_c = 1'b1;
                    p_next       = P_CSUM;
                end
                P_CSUM: begin
                    if (shift_q == csum_c) write_c = 1'b1;
                    else                   err_c   = 1'b1;
                    p_next = P_HUNT;
                end
                default: p_next = P_HUNT;
            endcase
        end
    end

    // Registered outputs and frame field latches
    always_ff @(posedge clk) begin
        if (reset) begin
            addr      <= '0;
            data_out  <= '0;
            write     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            addr_byte <= '0;
            data_byte <= '0;
        end else begin
            write     <= write_c;
            frame_err <= err_c;
            busy      <= (p_next != P_HUNT);
            if (latch_addr_c) addr_byte <= shift_q[2:0];
            if (latch_data_c) data_byte <= shift_q;
            if (write_c) begin
                addr     <= addr_byte;
                data_out <= data_byte;
            end
        end
    end

endmodule
